// File: rtl/run_monitor_pkg.sv
// Shared types for the run-completion monitor: FSM state encoding and fail codes.
package run_monitor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PASS = 2'd2,
    ST_FAIL = 2'd3
  } state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ADDR    = 2'd1;
  localparam logic [1:0] FC_HANG    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

endpackage

// File: rtl/run_monitor_pc_stall_detector.sv
// Tracks the previous fetch PC and counts consecutive cycles without a PC change.
module pc_stall_detector
  import run_monitor_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int STALL_LIMIT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [XLEN-1:0] pc_i,
  output logic            pc_changed_o,
  output logic            stalled_o
);

  localparam int            SW  = $clog2(STALL_LIMIT);
  localparam logic [SW-1:0] LIM = SW'(STALL_LIMIT - 1);

  logic [XLEN-1:0] prev_q;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic            same;

  assign same         = (pc_i == prev_q);
  assign pc_changed_o = en_i & ~same;
  assign stalled_o    = en_i & same & (cnt_q == LIM);

  // Counter parks at the limit; the FSM leaves RUN on that same cycle anyway.
  always_comb begin
    cnt_d = cnt_q;
    if (!same)            cnt_d = '0;
    else if (cnt_q != LIM) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset || clr_i) begin
      prev_q <= '0;
      cnt_q  <= '0;
    end else if (load_i) begin
      prev_q <= pc_i;
      cnt_q  <= '0;
    end else if (en_i) begin
      prev_q <= pc_i;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/run_monitor.sv
// Run-completion monitor: watches fetch PC and reports pass/fail/hang/timeout.
// Define RUN_MONITOR_TRACE_EN to compile in simulation-only trace messages.
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] PASS_ADDR   = 32'd160,
  parameter logic [XLEN-1:0] FAIL_ADDR   = 32'hFFFF_FFFC,
  parameter int              TIMEOUT     = 4096,
  parameter int              STALL_LIMIT = 64,
  parameter int              CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             clear,
  input  logic [XLEN-1:0]  PCF,
  input  logic [XLEN-1:0]  InstrF,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] fetch_count
);

  // Timeout runs on its own counter so a narrow CNT_W cannot mask it.
  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e           state_q;
  logic             busy_q, done_q, pass_q;
  logic [1:0]       fc_q;
  logic [CNT_W-1:0] cyc_q, cyc_d, fetch_q, fetch_d;
  logic [TW-1:0]    tmo_q;

  logic run, load, pc_changed, stalled;
  logic pass_hit, fail_hit, tmo_hit;
  logic unused_instr;

  assign run          = (state_q == ST_RUN);
  assign load         = (state_q == ST_IDLE) && start;
  assign pass_hit     = (PCF == PASS_ADDR);
  assign fail_hit     = (PCF == FAIL_ADDR);
  assign tmo_hit      = (tmo_q == TMO_LAST);
  assign unused_instr = ^InstrF;

  pc_stall_detector #(
    .XLEN        (XLEN),
    .STALL_LIMIT (STALL_LIMIT)
  ) u_stall (
    .clk          (clk),
    .reset        (reset),
    .clr_i        (clear),
    .load_i       (load),
    .en_i         (run),
    .pc_i         (PCF),
    .pc_changed_o (pc_changed),
    .stalled_o    (stalled)
  );

  always_comb begin
    cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 1'b1;
    fetch_d = fetch_q;
    if (pc_changed && !(&fetch_q)) fetch_d = fetch_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset || clear) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fc_q    <= FC_NONE;
      cyc_q   <= '0;
      fetch_q <= '0;
      tmo_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
            cyc_q   <= '0;
            fetch_q <= '0;
            tmo_q   <= '0;
          end
        end
        ST_RUN: begin
          cyc_q   <= cyc_d;
          fetch_q <= fetch_d;
          tmo_q   <= tmo_q + 1'b1;
          if (pass_hit) begin
            state_q <= ST_PASS;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= 1'b1;
          end else if (fail_hit || stalled || tmo_hit) begin
            state_q <= ST_FAIL;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            fc_q    <= fail_hit ? FC_ADDR : (stalled ? FC_HANG : FC_TIMEOUT);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_code   = fc_q;
  assign cycle_count = cyc_q;
  assign fetch_count = fetch_q;

`ifdef RUN_MONITOR_TRACE_EN
  always @(posedge clk) begin
    if (reset && !clear && run) begin
      if (pc_changed)
        $display("[run_monitor] cycle %0d PCF=%h InstrF=%h", cyc_q, PCF, InstrF);
      if (pass_hit)
        $display("[run_monitor] Simulation succeeded");
      else if (fail_hit || stalled || tmo_hit)
        $display("[run_monitor] run failed code=%0d PCF=%h",
                 fail_hit ? FC_ADDR : (stalled ? FC_HANG : FC_TIMEOUT), PCF);
    end
  end
`endif

endmodule

// File: tb/tb_run_monitor.sv
// Directed bench for run_monitor: default, short-timeout and narrow-counter instances.
module tb_run_monitor;

  logic        clk = 1'b0;
  logic        reset, clear;
  logic        start, start_t, start_s;
  logic [31:0] PCF, InstrF;

  logic        busy, done, pass;
  logic [1:0]  fc;
  logic [31:0] cyc, fetch;
  logic        busy_t, done_t, pass_t;
  logic [1:0]  fc_t;
  logic [31:0] cyc_t, fetch_t;
  logic        busy_s, done_s, pass_s;
  logic [1:0]  fc_s;
  logic [3:0]  cyc_s, fetch_s;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  run_monitor dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .PCF(PCF), .InstrF(InstrF),
    .busy(busy), .done(done), .pass(pass), .fail_code(fc),
    .cycle_count(cyc), .fetch_count(fetch));

  run_monitor #(.TIMEOUT(16)) dut_t (
    .clk(clk), .reset(reset), .start(start_t), .clear(clear), .PCF(PCF), .InstrF(InstrF),
    .busy(busy_t), .done(done_t), .pass(pass_t), .fail_code(fc_t),
    .cycle_count(cyc_t), .fetch_count(fetch_t));

  run_monitor #(.CNT_W(4), .TIMEOUT(40)) dut_s (
    .clk(clk), .reset(reset), .start(start_s), .clear(clear), .PCF(PCF), .InstrF(InstrF),
    .busy(busy_s), .done(done_s), .pass(pass_s), .fail_code(fc_s),
    .cycle_count(cyc_s), .fetch_count(fetch_s));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".busy"}, {31'd0, busy}, 32'd0);
    chk({tag, ".done"}, {31'd0, done}, 32'd0);
    chk({tag, ".pass"}, {31'd0, pass}, 32'd0);
    chk({tag, ".fc"}, {30'd0, fc}, 32'd0);
    chk({tag, ".cyc"}, cyc, 32'd0);
    chk({tag, ".fetch"}, fetch, 32'd0);
  endtask

  initial begin
    reset = 1'b0; clear = 1'b0; start = 1'b0; start_t = 1'b0; start_s = 1'b0;
    PCF = 32'd0; InstrF = 32'h0000_0013;
    tick(); tick();
    chk_idle("reset");
    reset = 1'b1;

    // Pass run: PC walks 0,4,...,160
    PCF = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.busy", {31'd0, busy}, 32'd1);
    chk("start.cyc", cyc, 32'd0);
    for (int i = 0; i <= 40; i++) begin
      PCF = 32'(4 * i); InstrF = 32'h1000_0000 + 32'(i);
      tick();
      if (i == 39) chk("pass.pre_done", {31'd0, done}, 32'd0);
    end
    chk("pass.done", {31'd0, done}, 32'd1);
    chk("pass.pass", {31'd0, pass}, 32'd1);
    chk("pass.busy", {31'd0, busy}, 32'd0);
    chk("pass.fc", {30'd0, fc}, 32'd0);
    chk("pass.fetch", fetch, 32'd40);
    chk("pass.cyc", cyc, 32'd41);

    // start while in PASS is ignored; counters frozen
    PCF = 32'd500; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pass_start.pass", {31'd0, pass}, 32'd1);
    chk("pass_start.busy", {31'd0, busy}, 32'd0);
    chk("pass_start.cyc", cyc, 32'd41);
    chk("pass_start.fetch", fetch, 32'd40);

    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_idle("clear");

    // Fail address at RUN cycle 10
    PCF = 32'h100; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      PCF = 32'h100 + 32'(4 * i);
      tick();
    end
    PCF = 32'hFFFF_FFFC;
    tick();
    chk("faddr.done", {31'd0, done}, 32'd1);
    chk("faddr.pass", {31'd0, pass}, 32'd0);
    chk("faddr.fc", {30'd0, fc}, 32'd1);
    chk("faddr.cyc", cyc, 32'd11);
    chk("faddr.fetch", fetch, 32'd10);
    clear = 1'b1; tick(); clear = 1'b0;

    // Hang: PC parks at 0x40 from cycle 4, first stalled cycle is 5
    PCF = 32'h30; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      PCF = 32'h30 + 32'(4 * i);
      tick();
    end
    PCF = 32'h40;
    for (int i = 4; i <= 67; i++) tick();
    chk("hang.pre_done", {31'd0, done}, 32'd0);
    chk("hang.pre_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("hang.done", {31'd0, done}, 32'd1);
    chk("hang.fc", {30'd0, fc}, 32'd2);
    chk("hang.cyc", cyc, 32'd69);
    chk("hang.fetch", fetch, 32'd4);
    PCF = 32'h44;
    tick();
    chk("hang.fetch_frozen", fetch, 32'd4);
    chk("hang.cyc_frozen", cyc, 32'd69);
    clear = 1'b1; tick(); clear = 1'b0;

    // Reset asserted at RUN cycle 7
    PCF = 32'h300; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      PCF = 32'h300 + 32'(4 * i);
      tick();
    end
    chk("mid.busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle("midreset");

    // Timeout with TIMEOUT=16
    PCF = 32'h200; start_t = 1'b1;
    tick();
    start_t = 1'b0;
    for (int i = 0; i < 16; i++) begin
      PCF = 32'h200 + 32'(4 * i);
      tick();
      if (i == 14) chk("tmo.pre_done", {31'd0, done_t}, 32'd0);
    end
    chk("tmo.fc", {30'd0, fc_t}, 32'd3);
    chk("tmo.done", {31'd0, done_t}, 32'd1);
    chk("tmo.cyc", cyc_t, 32'd16);
    chk("tmo.fetch", fetch_t, 32'd15);
    chk("tmo.dut_idle", {31'd0, busy}, 32'd0);
    clear = 1'b1; tick(); clear = 1'b0;
    chk("tmo.clear", cyc_t, 32'd0);

    // PASS coinciding with the timeout cycle wins
    PCF = 32'h200; start_t = 1'b1;
    tick();
    start_t = 1'b0;
    for (int i = 0; i < 15; i++) begin
      PCF = 32'h200 + 32'(4 * i);
      tick();
    end
    PCF = 32'd160;
    tick();
    chk("tmo_pass.pass", {31'd0, pass_t}, 32'd1);
    chk("tmo_pass.fc", {30'd0, fc_t}, 32'd0);
    chk("tmo_pass.cyc", cyc_t, 32'd16);
    clear = 1'b1; tick(); clear = 1'b0;

    // Narrow counters saturate; timeout still fires at 40
    PCF = 32'h1000; start_s = 1'b1;
    tick();
    start_s = 1'b0;
    for (int i = 0; i < 40; i++) begin
      PCF = 32'h1000 + 32'(4 * (i + 1));
      tick();
      if (i == 20) begin
        chk("sat.mid_cyc", {28'd0, cyc_s}, 32'd15);
        chk("sat.mid_fetch", {28'd0, fetch_s}, 32'd15);
      end
      if (i == 38) chk("sat.pre_done", {31'd0, done_s}, 32'd0);
    end
    chk("sat.fc", {30'd0, fc_s}, 32'd3);
    chk("sat.cyc", {28'd0, cyc_s}, 32'd15);
    chk("sat.fetch", {28'd0, fetch_s}, 32'd15);
    chk("sat.pass", {31'd0, pass_s}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/run_monitor.md
# run_monitor

Synthesizable run-completion monitor that observes the fetch-stage program counter and instruction of the pipelined core and reports pass, fail, hang or timeout with registered status flags and counters. It replaces hand-written end-of-test checks in benches and can also be instantiated beside `TOP` on FPGA to drive status LEDs. It is a parametrised generalisation with these features:

- Configurable pass and fail addresses.
- Cycle timeout.
- PC-stall (hang) detection.
- Fetch-advance counting.

## Interface
Parameters:
- `XLEN`, 32, width of PC and instruction buses.
- `PASS_ADDR`, 32'd160, fetch address that signals test success.
- `FAIL_ADDR`, 32'hFFFF_FFFC, fetch address that signals test failure; must differ from `PASS_ADDR`.
- `TIMEOUT`, 4096, maximum RUN cycles before timeout failure; must be ≥ 2.
- `STALL_LIMIT`, 64, consecutive cycles with unchanged `PCF` that count as a hang; must be ≥ 2.
- `CNT_W`, 32, width of the cycle and fetch counters.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low (0 = reset).
- `start` in 1: one-cycle pulse that arms the monitor from IDLE.
- `clear` in 1: returns the monitor to IDLE from any state.
- `PCF` in XLEN: fetch-stage PC.
- `InstrF` in XLEN: fetch-stage instruction; used only for trace.
- `busy` out 1: high in RUN.
- `done` out 1: high in PASS or FAIL (sticky).
- `pass` out 1: high in PASS (sticky).
- `fail_code` out 2: 0 none, 1 fail address, 2 hang, 3 timeout.
- `cycle_count` out CNT_W: cycles spent in RUN.
- `fetch_count` out CNT_W: RUN cycles where `PCF` differs from its previous value.

## Operation
States:
- IDLE: waits for `start`.
  - On `start`, go to RUN, clear the counters and load `prev_pc <= PCF`.
- RUN: on each cycle, evaluate in priority order:
  - `PCF == PASS_ADDR` → PASS.
  - `PCF == FAIL_ADDR` → FAIL with code 1.
  - Stall counter reaches `STALL_LIMIT-1` with `PCF == prev_pc` → FAIL with code 2.
  - `cycle_count == TIMEOUT-1` → FAIL with code 3.
  - Otherwise stay in RUN.
- PASS / FAIL: terminal states. They hold until `clear` or reset.

Counters and comparison:
- Stall counter: increments while `PCF == prev_pc` and resets to 0 on any change. `prev_pc` updates every RUN cycle.
- `cycle_count` increments every RUN cycle; `fetch_count` increments on each PC change. Both saturate at 2^CNT_W−1 and freeze in PASS/FAIL.
- Address comparison uses the full XLEN bits, with no masking.

Precedence:
- `clear` has priority over `start` and over all RUN transitions.
- `start` is ignored outside IDLE.

## Timing
- Reset state: IDLE. Reset values: `busy`=0, `done`=0, `pass`=0, `fail_code`=0, counters=0, `prev_pc`=0.
- Reset asserted mid-run forces IDLE on the next edge, with the same values.
- All outputs are registered. `done`/`pass`/`fail_code` rise on the edge after the cycle in which `PCF` matches, giving 1-cycle latency.
- `busy` rises on the edge after the cycle in which `start` is sampled.
- `clear` takes effect on the next edge. It zeroes all outputs and counters.
- Simultaneous events: when `PCF == PASS_ADDR` coincides with the timeout or stall limit, the result is PASS.
- Hang example: for a PC frozen from the first RUN cycle with `STALL_LIMIT`=64, `done` rises after 64 RUN cycles.

## Configuration
- Macro `RUN_MONITOR_TRACE_EN`, when defined, compiles in simulation-only `$display` statements:
  - Each PC change prints cycle, PCF and InstrF.
  - Entry to PASS prints "Simulation succeeded".
  - Entry to FAIL prints the fail code and PCF.
- When the macro is undefined, no system tasks are present and the block is fully synthesizable. Logic and timing are identical either way.

## Structure
- Package `run_monitor_pkg`:
  - State enum (IDLE, RUN, PASS, FAIL).
  - Fail-code constants (FC_NONE, FC_ADDR, FC_HANG, FC_TIMEOUT).
- Sub-module `pc_stall_detector`:
  - Holds `prev_pc`, the stall counter and the change strobe.
  - Parametrised by XLEN and STALL_LIMIT.
  - Outputs `pc_changed` and `stalled`.
- The FSM and saturating counters live in `run_monitor`.

## Test plan
- Defaults; `start`; `PCF` steps 0, 4, 8 … 160 → `done`=`pass`=1 on the edge after 160 is presented, `fetch_count`=40, `fail_code`=0.
- `PCF` reaches 32'hFFFF_FFFC at cycle 10 → FAIL, `fail_code`=1, `pass`=0, `cycle_count`=11.
- `PCF` held at 0x40 from RUN cycle 5, `STALL_LIMIT`=64 → `fail_code`=2 after cycle 68, `fetch_count` frozen.
- `TIMEOUT`=16, `PCF` increments without reaching 160 → `fail_code`=3, `cycle_count`=16. Variant with `PCF`=160 at cycle 15 → PASS.
- `reset`=0 at RUN cycle 7 → next edge IDLE, all outputs 0. `start` pulsed while in PASS is ignored. `clear` → IDLE, then a new `start` runs cleanly.
- `CNT_W`=4, `TIMEOUT`=40, PC changing every cycle → `cycle_count` and `fetch_count` saturate at 15, `fail_code`=3 at cycle 40.
